// File: rtl/seq_checker_pkg.sv
// seq_checker_pkg
// Shared definitions for the sequence checker and anything that decodes its
// state (bench, host-side decoder):
//   state_e : 2-bit FSM encoding HUNT=0, VERIFY=1, LOCKED=2
//   clog2   : constant-evaluable ceiling log2, used to size run/bad counters
package seq_checker_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_e;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return r;
  endfunction

endpackage

// File: rtl/seq_checker_sat_counter.sv
// sat_counter
// Saturating up-counter: increments on inc, sticks at all-ones, never wraps.
// Ports:
//   clk : clock, rising edge
//   rst : asynchronous reset, active-high (clears q)
//   inc : increment request this cycle
//   q   : current count (ERR_W bits)
module sat_counter #(
  parameter int ERR_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [ERR_W-1:0] q
);

  logic [ERR_W-1:0] q_q;
  logic [ERR_W-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (inc && (q_q != {ERR_W{1'b1}})) q_d = q_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) q_q <= '0;
    else     q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/seq_checker.sv
// seq_checker
// Receive-side continuity checker for a free-running W-bit count stream.
// Each valid sample must equal the previous sample plus one (mod 2^W).
// The checker hunts for a starting value, verifies LOCK_CNT consecutive
// increments before declaring lock, reports every mismatch seen while
// locked, and returns to HUNT after LOSS_CNT consecutive mismatches.
// Ports:
//   clk       : clock, rising edge
//   rst       : asynchronous reset, active-high
//   in_valid  : in_data carries a sample this cycle
//   in_data   : sampled count value (W bits)
//   locked    : stream verified continuous
//   err_pulse : one-cycle strobe per mismatch while locked
//   err_count : saturating count of mismatches while locked (ERR_W bits)
//   expected  : next value the checker expects (W bits)
// Optional (macro SEQ_CHECKER_CAPTURE_EN):
//   cap_valid : first locked mismatch since reset has been captured
//   cap_got   : in_data of that mismatch
//   cap_exp   : expected value at that mismatch
module seq_checker
  import seq_checker_pkg::*;
#(
  parameter int W        = 8,
  parameter int LOCK_CNT = 4,
  parameter int LOSS_CNT = 3,
  parameter int ERR_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [W-1:0]     in_data,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count,
`ifdef SEQ_CHECKER_CAPTURE_EN
  output logic             cap_valid,
  output logic [W-1:0]     cap_got,
  output logic [W-1:0]     cap_exp,
`endif
  output logic [W-1:0]     expected
);

  localparam int unsigned CNT_MAX = (LOCK_CNT > LOSS_CNT) ? LOCK_CNT : LOSS_CNT;
  localparam int unsigned RUN_W   = clog2(CNT_MAX) + 1;
  localparam logic [RUN_W-1:0] LOCK_V = RUN_W'(LOCK_CNT);
  localparam logic [RUN_W-1:0] LOSS_V = RUN_W'(LOSS_CNT);

  state_e           state_q,    state_d;
  logic [W-1:0]     expected_q, expected_d;
  logic [RUN_W-1:0] run_q,      run_d;
  logic [RUN_W-1:0] bad_q,      bad_d;
  logic             locked_q,   locked_d;
  logic             err_pulse_q, err_pulse_d;
  logic             err_inc;

  logic             match;
  logic [W-1:0]     resync;
  logic [W-1:0]     exp_inc;
  logic [RUN_W-1:0] run_inc;
  logic [RUN_W-1:0] bad_inc;

  always_comb begin
    match   = (in_data == expected_q);
    resync  = in_data + 1'b1;
    exp_inc = expected_q + 1'b1;
    run_inc = run_q + 1'b1;
    bad_inc = bad_q + 1'b1;

    state_d     = state_q;
    expected_d  = expected_q;
    run_d       = run_q;
    bad_d       = bad_q;
    locked_d    = locked_q;
    err_pulse_d = 1'b0;
    err_inc     = 1'b0;

    if (in_valid) begin
      unique case (state_q)
        HUNT: begin
          // First sample only seeds the prediction; lock needs real matches.
          expected_d = resync;
          run_d      = '0;
          state_d    = VERIFY;
        end
        VERIFY: begin
          if (match) begin
            expected_d = exp_inc;
            if (run_inc == LOCK_V) begin
              state_d  = LOCKED;
              locked_d = 1'b1;
              run_d    = '0;
              bad_d    = '0;
            end else begin
              run_d = run_inc;
            end
          end else begin
            expected_d = resync;
            run_d      = '0;
          end
        end
        LOCKED: begin
          if (match) begin
            expected_d = exp_inc;
            bad_d      = '0;
          end else begin
            err_pulse_d = 1'b1;
            err_inc     = 1'b1;
            expected_d  = resync;
            if (bad_inc == LOSS_V) begin
              state_d  = HUNT;
              locked_d = 1'b0;
              bad_d    = '0;
              run_d    = '0;
            end else begin
              bad_d = bad_inc;
            end
          end
        end
        default: begin
          state_d  = HUNT;
          locked_d = 1'b0;
          run_d    = '0;
          bad_d    = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= HUNT;
      expected_q  <= '0;
      run_q       <= '0;
      bad_q       <= '0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      expected_q  <= expected_d;
      run_q       <= run_d;
      bad_q       <= bad_d;
      locked_q    <= locked_d;
      err_pulse_q <= err_pulse_d;
    end
  end

  sat_counter #(
    .ERR_W (ERR_W)
  ) u_err_cnt (
    .clk (clk),
    .rst (rst),
    .inc (err_inc),
    .q   (err_count)
  );

`ifdef SEQ_CHECKER_CAPTURE_EN
  logic         cap_valid_q, cap_valid_d;
  logic [W-1:0] cap_got_q,   cap_got_d;
  logic [W-1:0] cap_exp_q,   cap_exp_d;

  // Only the first locked mismatch is kept; later errors never overwrite it.
  always_comb begin
    cap_valid_d = cap_valid_q;
    cap_got_d   = cap_got_q;
    cap_exp_d   = cap_exp_q;
    if (err_inc && !cap_valid_q) begin
      cap_valid_d = 1'b1;
      cap_got_d   = in_data;
      cap_exp_d   = expected_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_valid_q <= 1'b0;
      cap_got_q   <= '0;
      cap_exp_q   <= '0;
    end else begin
      cap_valid_q <= cap_valid_d;
      cap_got_q   <= cap_got_d;
      cap_exp_q   <= cap_exp_d;
    end
  end

  assign cap_valid = cap_valid_q;
  assign cap_got   = cap_got_q;
  assign cap_exp   = cap_exp_q;
`endif

  assign locked    = locked_q;
  assign err_pulse = err_pulse_q;
  assign expected  = expected_q;

endmodule
